// File: rtl/diff_operand_loader.sv
// diff_operand_loader
// Assembles two OP_W-bit operands (A, then B) from a byte stream, presents
// them to the combinational diff unit for one EVAL cycle, then captures the
// diff index and an equality flag behind a valid/ready result handshake.
// Optional build macro: DIFF_LOADER_MSB_FIRST_EN -- when defined, the first
// byte of each operand fills the most significant lane (big-endian fill).
module diff_operand_loader #(
  parameter int OP_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic [OP_W-1:0]  op_a,
  output logic [OP_W-1:0]  op_b,
  output logic             op_valid,
  input  logic [4:0]       diff_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [4:0]       res_diff,
  output logic             res_equal,
  output logic [CNT_W-1:0] res_count
);

  localparam int LANES = OP_W / 8;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LANES - 1);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, EVAL, HOLD} state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [IDX_W-1:0] lane_idx;
  logic [LANES-1:0] lane_sel;
  logic             accept;

  // in_ready is a registered copy of "state is LOAD_A or LOAD_B", so a byte
  // can only be taken while loading.
  assign accept = in_valid & in_ready;

  // idx always counts up; the fill order only changes which lane it maps to.
`ifdef DIFF_LOADER_MSB_FIRST_EN
  assign lane_idx = IDX_LAST - idx_reg;
`else
  assign lane_idx = idx_reg;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_sel[gi] = (lane_idx == IDX_W'(gi));
    end
  endgenerate

  // Operand capture: an accepted byte lands in the selected lane of A or B;
  // operands otherwise persist across EVAL, HOLD and clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
    end else if (!clear && accept) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_sel[l]) begin
          if (state_reg == LOAD_A) op_a[l*8 +: 8] <= in_data;
          else                     op_b[l*8 +: 8] <= in_data;
        end
      end
    end
  end

  // Control FSM with registered handshake outputs and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= LOAD_A;
      idx_reg   <= '0;
      in_ready  <= 1'b1;
      op_valid  <= 1'b0;
      res_valid <= 1'b0;
      res_diff  <= '0;
      res_equal <= 1'b0;
      res_count <= '0;
    end else if (clear) begin
      // Abort: restart loading, keep operands, last result and count.
      state_reg <= LOAD_A;
      idx_reg   <= '0;
      in_ready  <= 1'b1;
      op_valid  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state_reg)
        LOAD_A: begin
          if (accept) begin
            if (idx_reg == IDX_LAST) begin
              idx_reg   <= '0;
              state_reg <= LOAD_B;
            end else begin
              idx_reg <= idx_reg + IDX_W'(1);
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            if (idx_reg == IDX_LAST) begin
              idx_reg   <= '0;
              state_reg <= EVAL;
              in_ready  <= 1'b0;
              op_valid  <= 1'b1;
            end else begin
              idx_reg <= idx_reg + IDX_W'(1);
            end
          end
        end
        EVAL: begin
          res_diff  <= diff_in;
          res_equal <= (op_a == op_b);
          op_valid  <= 1'b0;
          res_valid <= 1'b1;
          state_reg <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_count <= res_count + CNT_W'(1);
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= LOAD_A;
          end
        end
        default: begin
          state_reg <= LOAD_A;
          idx_reg   <= '0;
          in_ready  <= 1'b1;
          op_valid  <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_diff_operand_loader.sv
// tb_diff_operand_loader
// Scoreboard bench: the stimulus process pushes the expected result of every
// operand pair it loads; a negedge monitor pops and compares whenever a new
// result appears, and checks hold/handshake/clear behaviour around it.
// Honours DIFF_LOADER_MSB_FIRST_EN for the byte order it sends.
module tb_diff_operand_loader;

  localparam int OP_W  = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_ready;
  logic [OP_W-1:0]  op_a;
  logic [OP_W-1:0]  op_b;
  logic             op_valid;
  logic [4:0]       diff_in;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [4:0]       res_diff;
  logic             res_equal;
  logic [CNT_W-1:0] res_count;

  always #5 clk = ~clk;

  diff_operand_loader #(.OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .diff_in(diff_in),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_diff(res_diff), .res_equal(res_equal), .res_count(res_count)
  );

  // Reference for the diff unit: 1-based index of the lowest differing bit,
  // 0 when equal, kept to 5 bits.
  function automatic logic [4:0] ref_diff(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 32; i++) begin
      if (a[i] != b[i]) return 5'(i + 1);
    end
    return 5'd0;
  endfunction

  // Stand-in for the external combinational diff unit.
  assign diff_in = ref_diff(op_a, op_b);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  d;
    logic        eq;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int   count_model = 0;
  int   txn_no = 0;
  logic prev_res_valid = 1'b0;
  logic prev_op_valid = 1'b0;
  logic hs_pend = 1'b0;
  logic clr_pend = 1'b0;
  exp_t cur = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      count_model    = 0;
      prev_res_valid = 1'b0;
      prev_op_valid  = 1'b0;
      hs_pend        = 1'b0;
      clr_pend       = 1'b0;
    end else begin
      if (hs_pend) begin
        check("after_handshake_res_valid", res_valid, 0);
        check("after_handshake_in_ready", in_ready, 1);
        check("after_handshake_res_count", res_count, count_model);
      end
      if (clr_pend) begin
        check("after_clear_res_valid", res_valid, 0);
        check("after_clear_in_ready", in_ready, 1);
        check("after_clear_res_count", res_count, count_model);
      end
      if (op_valid) check("eval_in_ready", in_ready, 0);
      if (res_valid && !prev_res_valid) begin
        check("eval_precedes_result", prev_op_valid, 1);
        check("hold_op_valid", op_valid, 0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got diff=%0d, required no result", res_diff);
        end else begin
          cur = exp_q.pop_front();
          txn_no++;
          $display("txn %0d: a=%08h b=%08h diff=%0d equal=%0d count=%0d",
                   txn_no, op_a, op_b, res_diff, res_equal, res_count);
          check("op_a", op_a, cur.a);
          check("op_b", op_b, cur.b);
          check("res_diff", res_diff, cur.d);
          check("res_equal", res_equal, cur.eq);
          check("res_count_before_handshake", res_count, count_model);
        end
      end else if (res_valid) begin
        check("hold_res_diff_stable", res_diff, cur.d);
        check("hold_res_equal_stable", res_equal, cur.eq);
        check("hold_in_ready", in_ready, 0);
      end
      hs_pend  = res_valid && res_ready && !clear;
      clr_pend = clear;
      if (hs_pend) count_model++;
      prev_res_valid = res_valid;
      prev_op_valid  = op_valid;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] d);
    int budget;
    budget = 0;
    while ($urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      budget++;
      if (budget > 50) begin
        n_cmp++;
        n_bad++;
        $display("FAIL byte_accept_timeout: in_ready=%0d, required 1", in_ready);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int lane;
    for (int k = 0; k < 4; k++) begin
`ifdef DIFF_LOADER_MSB_FIRST_EN
      lane = 3 - k;
`else
      lane = k;
`endif
      send_byte(w[lane*8 +: 8]);
    end
  endtask

  task automatic load_pair(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.a  = a;
    e.b  = b;
    e.d  = ref_diff(a, b);
    e.eq = (a == b);
    exp_q.push_back(e);
    send_word(a);
    send_word(b);
  endtask

  task automatic wait_res_valid();
    int t;
    t = 0;
    @(negedge clk);
    while (!res_valid && t < 20) begin
      t++;
      @(negedge clk);
    end
    if (!res_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL result_timeout: res_valid=%0d, required 1", res_valid);
    end
  endtask

  task automatic finish_txn(input int hold);
    res_ready = (hold == 0);
    wait_res_valid();
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      res_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input int hold);
    load_pair(a, b);
    finish_txn(hold);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          mode;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_res_valid", res_valid, 0);
    check("reset_op_valid", op_valid, 0);
    check("reset_res_count", res_count, 0);
    check("reset_op_a", op_a, 0);
    check("reset_op_b", op_b, 0);
    check("reset_res_diff", res_diff, 0);
    check("reset_res_equal", res_equal, 0);
    @(posedge clk); #1;

    // directed cases
    run_txn(32'h0000_0001, 32'h0000_0000, 0);
    run_txn(32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    run_txn(32'h0000_0100, 32'h0000_0000, 5);
    run_txn(32'h0000_0002, 32'h0000_0000, 1);

    // abort after two B bytes; clear wins over a valid byte in the same cycle
    send_word(32'h1122_3344);
    send_byte(8'hAA);
    send_byte(8'h55);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("clear_midload_op_valid", op_valid, 0);
    @(posedge clk); #1;
    run_txn(32'h0000_0004, 32'h0000_0000, 1);

    // clear and res_ready together in HOLD: no handshake counted
    load_pair(32'h0000_00F0, 32'h0000_000F);
    res_ready = 1'b0;
    wait_res_valid();
    @(posedge clk); #1;
    clear     = 1'b1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    clear     = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    check("clear_keeps_op_a", op_a, 32'h0000_00F0);
    check("clear_keeps_res_diff", res_diff, 5'd1);
    @(posedge clk); #1;

    // asynchronous reset while holding a result
    load_pair(32'h0000_1234, 32'h0000_1230);
    res_ready = 1'b0;
    wait_res_valid();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_res_valid", res_valid, 0);
    check("async_reset_res_count", res_count, 0);
    check("async_reset_op_a", op_a, 0);
    check("async_reset_op_b", op_b, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1);
    check("post_reset_res_valid", res_valid, 0);
    @(posedge clk); #1;

    // randomized operand pairs
    for (int n = 0; n < 40; n++) begin
      ra   = $urandom;
      mode = $urandom_range(0, 2);
      if (mode == 0)      rb = ra;
      else if (mode == 1) rb = ra ^ (32'h1 << $urandom_range(0, 31));
      else                rb = $urandom;
      run_txn(ra, rb, $urandom_range(0, 3));
    end

    repeat (5) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
